// File: rtl/usart_core_pkg.sv
// Shared USART constants, state encodings and bit helpers; combinational only.
// No latency, no flow control.
package usart_core_pkg;

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int         TICKS_PER_BIT = 16;
  localparam logic [3:0] TICK_LAST     = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0] PH_EARLY      = 4'd7;
  localparam logic [3:0] PH_MID        = 4'd8;
  localparam logic [3:0] PH_LATE       = 4'd9;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Data is zero-padded to 9 bits; padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// x16 tick generator (pulse every max(divider,1) cycles) and x1 square wave (toggles every 8 ticks).
// Free running, no backpressure; divider changes apply at the next reload.
module usart_baud_gen #(
  parameter int DIV_WIDTH = 12
) (
  input  logic                 comm_clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic                 tick,
  output logic                 bit_clk
);
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [2:0]           tick_cnt;

  assign div_eff = (divider == '0) ? DIV_WIDTH'(1) : divider;

  // >= rather than == so shrinking the divider below the current count reloads at once.
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      tick     <= 1'b0;
      tick_cnt <= '0;
      bit_clk  <= 1'b0;
    end else begin
      if (cnt >= div_eff - DIV_WIDTH'(1)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_WIDTH'(1);
        tick <= 1'b0;
      end
      if (tick) begin
        tick_cnt <= tick_cnt + 3'd1;
        if (tick_cnt == 3'd7) bit_clk <= ~bit_clk;
      end
    end
  end
endmodule

// File: rtl/usart_core.sv
// USART: TX/RX engines with runtime parity/stop modes and a first-word-fall-through RX FIFO.
// TX accepts only when idle (tx_ready); RX drops words into a full FIFO and pulses rx_overrun.
module usart_core
  import usart_core_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 12,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 comm_clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] clock_divider,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_error,
  output logic                 rx_framing_error,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 tx_pin,
  input  logic                 rx_pin,
  output logic                 bit_clock_x16,
  output logic                 bit_clock_x1
);
  localparam int         AW       = $clog2(RX_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef struct packed {
    logic                 framing;
    logic                 parity;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  logic tick;

  usart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .comm_clock (comm_clock),
    .reset      (reset),
    .divider    (clock_divider),
    .tick       (tick),
    .bit_clk    (bit_clock_x1)
  );
  assign bit_clock_x16 = tick;

  // ---------------- TX ----------------
  tx_state_t            tx_state;
  logic                 tx_pend, tx_par_en, tx_par_val, tx_two_stop, tx_stop2;
  logic [DATA_BITS-1:0] tx_shift;
  logic [3:0]           tx_tcnt, tx_idx;
  logic [8:0]           tx_pad, rx_pad;
  logic                 tx_bit_end;

  always_comb begin
    tx_pad = '0;
    tx_pad[DATA_BITS-1:0] = tx_data;
  end

  assign tx_bit_end = tick && (tx_tcnt == TICK_LAST);

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_pin      <= 1'b1;
      tx_ready    <= 1'b1;
      tx_pend     <= 1'b0;
      tx_shift    <= '0;
      tx_par_en   <= 1'b0;
      tx_par_val  <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_tcnt     <= '0;
      tx_idx      <= '0;
    end else begin
      if (tick && tx_state != TX_IDLE) tx_tcnt <= tx_tcnt + 4'd1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_ready    <= 1'b0;
            tx_pend     <= 1'b1;
            tx_shift    <= tx_data;
            tx_par_en   <= parity_on(parity_mode);
            tx_par_val  <= parity_bit(tx_pad, parity_mode);
            tx_two_stop <= two_stop;
          end else if (tx_pend && tick) begin
            tx_pend  <= 1'b0;
            tx_state <= TX_START;
            tx_pin   <= 1'b0;
            tx_tcnt  <= '0;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_state <= TX_DATA;
          tx_pin   <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_idx   <= '0;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_idx != LAST_BIT) begin
            tx_idx   <= tx_idx + 4'd1;
            tx_pin   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else if (tx_par_en) begin
            tx_state <= TX_PARITY;
            tx_pin   <= tx_par_val;
          end else begin
            tx_state <= TX_STOP;
            tx_pin   <= 1'b1;
            tx_stop2 <= tx_two_stop;
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_state <= TX_STOP;
          tx_pin   <= 1'b1;
          tx_stop2 <= tx_two_stop;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_stop2) begin
            tx_stop2 <= 1'b0;
          end else begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  rx_state_t            rx_state;
  logic [1:0]           rx_sync, rx_mode;
  logic                 rx_s, s_early, s_mid, rx_vote, rx_par_err, push_vld;
  logic [3:0]           rx_tcnt, rx_idx, rx_phase;
  logic [DATA_BITS-1:0] rx_shift;
  rx_entry_t            push_dat;

  always_comb begin
    rx_pad = '0;
    rx_pad[DATA_BITS-1:0] = rx_shift;
  end

  assign rx_s     = rx_sync[1];
  assign rx_phase = rx_tcnt + 4'd1;
  assign rx_vote  = majority(s_early, s_mid, rx_s);

  // rx_tcnt counts ticks since the bit began; rx_phase is the index of the current tick.
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      rx_sync    <= 2'b11;
      rx_state   <= RX_IDLE;
      rx_mode    <= '0;
      rx_tcnt    <= '0;
      rx_idx     <= '0;
      s_early    <= 1'b1;
      s_mid      <= 1'b1;
      rx_shift   <= '0;
      rx_par_err <= 1'b0;
      push_vld   <= 1'b0;
      push_dat   <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_pin};
      push_vld <= 1'b0;
      if (tick) begin
        rx_tcnt <= rx_phase;
        if (rx_phase == PH_EARLY) s_early <= rx_s;
        if (rx_phase == PH_MID)   s_mid   <= rx_s;
      end
      case (rx_state)
        RX_IDLE: if (tick && !rx_s) begin
          rx_state   <= RX_START;
          rx_tcnt    <= '0;
          rx_mode    <= parity_mode;
          rx_par_err <= 1'b0;
        end
        RX_START: if (tick) begin
          if (rx_phase == PH_MID && rx_s) rx_state <= RX_IDLE;
          else if (rx_tcnt == TICK_LAST) begin
            rx_state <= RX_DATA;
            rx_idx   <= '0;
          end
        end
        RX_DATA: if (tick) begin
          if (rx_phase == PH_LATE) rx_shift <= {rx_vote, rx_shift[DATA_BITS-1:1]};
          if (rx_tcnt == TICK_LAST) begin
            if (rx_idx != LAST_BIT) rx_idx <= rx_idx + 4'd1;
            else rx_state <= parity_on(rx_mode) ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (tick) begin
          if (rx_phase == PH_LATE) rx_par_err <= (rx_vote != parity_bit(rx_pad, rx_mode));
          if (rx_tcnt == TICK_LAST) rx_state <= RX_STOP;
        end
        // Only the first stop bit is checked; the word is pushed at its vote.
        RX_STOP: if (tick && rx_phase == PH_LATE) begin
          push_vld <= 1'b1;
          push_dat <= '{framing: ~rx_vote, parity: rx_par_err, data: rx_shift};
          rx_state <= rx_vote ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (rx_s) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  rx_entry_t mem [RX_DEPTH];
  rx_entry_t head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rx_ready && !empty;
  assign push_ok = push_vld && (!full || pop);

  always_ff @(posedge comm_clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      rx_overrun <= push_vld && full && !pop;
    end
  end

  assign head             = mem[rd_ptr[AW-1:0]];
  assign rx_valid         = !empty;
  assign rx_data          = head.data;
  assign rx_parity_error  = head.parity;
  assign rx_framing_error = head.framing;
endmodule

// File: tb/tb_usart_core.sv
// Directed bench for usart_core: reset, baud ticks, TX waveform, loopback, RX errors, overrun, reset abort.
module tb_usart_core;
  localparam int DATA_BITS = 8;
  localparam int DIV_WIDTH = 12;
  localparam int RX_DEPTH  = 4;

  logic                 comm_clock = 1'b0;
  logic                 reset = 1'b1;
  logic [DIV_WIDTH-1:0] clock_divider = 12'd4;
  logic [1:0]           parity_mode = 2'b00;
  logic                 two_stop = 1'b0;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_error, rx_framing_error, rx_valid;
  logic                 rx_ready = 1'b0;
  logic                 rx_overrun, tx_pin, rx_pin, bit_clock_x16, bit_clock_x1;
  logic                 loopback = 1'b0;
  logic                 rx_drv = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int ovr_seen = 0;
  int bit_cyc = 64;

  usart_core #(.DATA_BITS(DATA_BITS), .DIV_WIDTH(DIV_WIDTH), .RX_DEPTH(RX_DEPTH)) dut (
    .comm_clock(comm_clock), .reset(reset), .clock_divider(clock_divider),
    .parity_mode(parity_mode), .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_parity_error(rx_parity_error),
    .rx_framing_error(rx_framing_error), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_pin(tx_pin), .rx_pin(rx_pin),
    .bit_clock_x16(bit_clock_x16), .bit_clock_x1(bit_clock_x1)
  );

  always #5 comm_clock = ~comm_clock;
  assign rx_pin = loopback ? tx_pin : rx_drv;

  always @(negedge comm_clock) if (rx_overrun) ovr_seen++;

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (bit_cyc) @(negedge comm_clock);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic use_par, input logic pbit,
                             input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(stop_v);
  endtask

  task automatic pop_head();
    rx_ready = 1'b1;
    @(negedge comm_clock);
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    @(negedge comm_clock);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge comm_clock);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge comm_clock);
    vectors++; if (tx_pin !== 1'b1) begin miscompares++; $display("FAIL reset_tx_pin got %b want 1", tx_pin); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    vectors++; if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_rx_overrun got %b want 0", rx_overrun); end
    vectors++; if (bit_clock_x16 !== 1'b0) begin miscompares++; $display("FAIL reset_x16 got %b want 0", bit_clock_x16); end
    vectors++; if (bit_clock_x1 !== 1'b0) begin miscompares++; $display("FAIL reset_x1 got %b want 0", bit_clock_x1); end
    reset = 1'b0;
    repeat (4) @(negedge comm_clock);
  endtask

  task automatic test_baud();
    int pulses, toggles;
    logic prev;
    clock_divider = 12'd4;
    repeat (20) @(negedge comm_clock);
    pulses = 0;
    repeat (64) begin @(negedge comm_clock); if (bit_clock_x16) pulses++; end
    vectors++; if (pulses !== 16) begin miscompares++; $display("FAIL baud_div4_ticks got %0d want 16", pulses); end
    toggles = 0;
    prev = bit_clock_x1;
    repeat (256) begin
      @(negedge comm_clock);
      if (bit_clock_x1 !== prev) toggles++;
      prev = bit_clock_x1;
    end
    vectors++; if (toggles !== 8) begin miscompares++; $display("FAIL baud_x1_toggles got %0d want 8", toggles); end
    clock_divider = 12'd0;
    repeat (10) @(negedge comm_clock);
    pulses = 0;
    repeat (20) begin @(negedge comm_clock); if (bit_clock_x16) pulses++; end
    vectors++; if (pulses !== 20) begin miscompares++; $display("FAIL baud_div0_ticks got %0d want 20", pulses); end
    clock_divider = 12'd4;
    repeat (20) @(negedge comm_clock);
  endtask

  task automatic test_tx_55();
    logic [9:0] frame;
    int n, n_fall, n_ready, rel, lows;
    frame = {1'b1, 8'h55, 1'b0};
    clock_divider = 12'd32;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    repeat (100) @(negedge comm_clock);
    send_word(8'h55);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL tx_ready_fall got %b want 0", tx_ready); end
    n = 0; n_fall = -1; n_ready = -1; lows = 0;
    while (n < 6000 && n_ready < 0) begin
      @(negedge comm_clock);
      n++;
      if (n_fall < 0 && tx_pin == 1'b0) n_fall = n;
      if (n_fall >= 0) begin
        rel = n - n_fall;
        if (rel < 512 && tx_pin == 1'b0) lows++;
        if (rel == 512) begin
          vectors++; if (tx_pin !== 1'b1) begin miscompares++; $display("FAIL tx_start_end got %b want 1", tx_pin); end
        end
        if (rel < 5120 && (rel % 512) == 256) begin
          vectors++;
          if (tx_pin !== frame[rel / 512]) begin
            miscompares++; $display("FAIL tx_bit%0d got %b want %b", rel / 512, tx_pin, frame[rel / 512]);
          end
        end
      end
      if (tx_ready) n_ready = n;
    end
    vectors++; if (lows !== 512) begin miscompares++; $display("FAIL tx_start_len got %0d want 512", lows); end
    vectors++;
    if (n_ready < 0 || n_ready > 5152) begin
      miscompares++; $display("FAIL tx_ready_return got %0d want 1..5152", n_ready);
    end
    repeat (50) @(negedge comm_clock);
    vectors++; if (tx_pin !== 1'b1) begin miscompares++; $display("FAIL tx_idle_high got %b want 1", tx_pin); end
    clock_divider = 12'd4;
    repeat (50) @(negedge comm_clock);
  endtask

  task automatic test_loopback_even();
    int n;
    parity_mode = 2'b01;
    loopback = 1'b1;
    send_word(8'hA3);
    n = 0;
    while (!rx_valid && n < 2000) begin @(negedge comm_clock); n++; end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL loop_valid got %b want 1", rx_valid); end
    vectors++; if (rx_data !== 8'hA3) begin miscompares++; $display("FAIL loop_data got %h want a3", rx_data); end
    vectors++; if (rx_parity_error !== 1'b0) begin miscompares++; $display("FAIL loop_par got %b want 0", rx_parity_error); end
    vectors++; if (rx_framing_error !== 1'b0) begin miscompares++; $display("FAIL loop_frm got %b want 0", rx_framing_error); end
    pop_head();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL loop_pop got %b want 0", rx_valid); end
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge comm_clock); n++; end
    repeat (bit_cyc) @(negedge comm_clock);
    loopback = 1'b0;
  endtask

  task automatic test_parity_error();
    parity_mode = 2'b10;
    drive_frame(8'h0F, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL par_valid got %b want 1", rx_valid); end
    vectors++; if (rx_data !== 8'h0F) begin miscompares++; $display("FAIL par_data got %h want 0f", rx_data); end
    vectors++; if (rx_parity_error !== 1'b1) begin miscompares++; $display("FAIL par_flag got %b want 1", rx_parity_error); end
    vectors++; if (rx_framing_error !== 1'b0) begin miscompares++; $display("FAIL par_frm got %b want 0", rx_framing_error); end
    pop_head();
  endtask

  task automatic test_break();
    parity_mode = 2'b00;
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) drive_bit(1'b0);
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL brk_valid got %b want 1", rx_valid); end
    vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL brk_data got %h want 3c", rx_data); end
    vectors++; if (rx_framing_error !== 1'b1) begin miscompares++; $display("FAIL brk_frm got %b want 1", rx_framing_error); end
    pop_head();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL brk_single got %b want 0", rx_valid); end
    repeat (12) drive_bit(1'b1);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL brk_no_more got %b want 0", rx_valid); end
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL brk_recover got %h want 5a", rx_data); end
    vectors++; if (rx_framing_error !== 1'b0) begin miscompares++; $display("FAIL brk_recover_frm got %b want 0", rx_framing_error); end
    pop_head();
  endtask

  task automatic test_overrun();
    int base;
    logic [7:0] w;
    base = ovr_seen;
    for (int i = 1; i <= 5; i++) begin
      w = 8'(i);
      drive_frame(w, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1);
    end
    vectors++; if (ovr_seen - base !== 1) begin miscompares++; $display("FAIL ovr_pulses got %0d want 1", ovr_seen - base); end
    for (int i = 1; i <= 4; i++) begin
      w = 8'(i);
      vectors++;
      if (rx_valid !== 1'b1 || rx_data !== w) begin
        miscompares++; $display("FAIL ovr_pop%0d got %b/%h want 1/%h", i, rx_valid, rx_data, w);
      end
      pop_head();
    end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch_and_reset();
    int n;
    rx_drv = 1'b0;
    repeat (16) @(negedge comm_clock);
    rx_drv = 1'b1;
    repeat (2 * bit_cyc) @(negedge comm_clock);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_word got %b want 0", rx_valid); end
    send_word(8'h00);
    n = 0;
    while (tx_pin && n < 500) begin @(negedge comm_clock); n++; end
    repeat (100) @(negedge comm_clock);
    vectors++; if (tx_pin !== 1'b0) begin miscompares++; $display("FAIL midtx_low got %b want 0", tx_pin); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (tx_pin !== 1'b1) begin miscompares++; $display("FAIL rst_tx_pin got %b want 1", tx_pin); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
    @(negedge comm_clock);
    reset = 1'b0;
    repeat (2 * bit_cyc) @(negedge comm_clock);
    vectors++; if (tx_pin !== 1'b1) begin miscompares++; $display("FAIL post_rst_idle got %b want 1", tx_pin); end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_tx_55();
    test_loopback_even();
    test_parity_error();
    test_break();
    test_overrun();
    test_glitch_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
